flex_down_counter: RTL



---
 rtl/flex_counter_pkg.sv | 14 +
 rtl/flex_down_counter.sv | 105 ++++++++++
 2 files changed

// File: rtl/flex_counter_pkg.sv
// Shared definitions for the flex counter family (up and down counters).
package flex_counter_pkg;

    // Width used by flex_counter and flex_down_counter unless overridden
    localparam int DEFAULT_NUM_BITS = 4;

    // Down-counter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } down_state_t;

endpackage

// File: rtl/flex_down_counter.sv
// Programmable down-counting timer: loads a start value, decrements once
// per enabled cycle, flags expiry at zero and optionally auto-reloads so
// it can produce periodic ticks.
module flex_down_counter
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic                count_enable,
    input  logic                auto_reload,
    output logic [NUM_BITS-1:0] count_out,
    output logic                busy,
    output logic                expired_flag,
    output logic                expire_pulse
);

    localparam logic [NUM_BITS-1:0] ZERO = '0;
    localparam logic [NUM_BITS-1:0] ONE  = NUM_BITS'(1);

    down_state_t         state;
    down_state_t         next_state;
    logic [NUM_BITS-1:0] reload_reg;
    logic [NUM_BITS-1:0] next_count;
    logic [NUM_BITS-1:0] next_reload;
    logic                next_pulse;
    logic                next_busy;
    logic                next_expired;

    // Next-state, next-count and expiry decode; clear beats load beats counting
    always_comb begin
        next_state  = state;
        next_count  = count_out;
        next_reload = reload_reg;
        next_pulse  = 1'b0;

        if (clear) begin
            next_state = IDLE;
            next_count = ZERO;
        end else if (load) begin
            next_reload = load_val;
            next_count  = load_val;
            next_state  = (load_val == ZERO) ? IDLE : RUN;
        end else begin
            case (state)
                IDLE: begin
                    next_state = IDLE;
                end
                RUN: begin
                    if (count_enable) begin
                        if (count_out > ONE) begin
                            next_count = count_out - ONE;
                        end else if (count_out == ONE) begin
                            next_pulse = 1'b1;
                            if (auto_reload) begin
                                next_count = reload_reg;
                            end else begin
                                next_count = ZERO;
                                next_state = DONE;
                            end
                        end else begin
                            // A zero count while running is never decremented;
                            // fall back to IDLE rather than underflow.
                            next_state = IDLE;
                        end
                    end
                end
                DONE: begin
                    next_count = ZERO;
                end
                default: begin
                    next_state = IDLE;
                    next_count = ZERO;
                end
            endcase
        end

        next_busy    = (next_state == RUN);
        next_expired = (next_state == DONE);
    end

    // State, count, reload value and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count_out    <= ZERO;
            reload_reg   <= ZERO;
            busy         <= 1'b0;
            expired_flag <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            count_out    <= next_count;
            reload_reg   <= next_reload;
            busy         <= next_busy;
            expired_flag <= next_expired;
            expire_pulse <= next_pulse;
        end
    end

endmodule
